// File: rtl/ni_packetizer_pkg.sv
// Shared definitions for the router0 network interface: flit codes, port codes, mesh geometry, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ni_packetizer_pkg;

    // Flit type codes carried alongside every flit
    localparam logic [1:0] HDR_FLIT  = 2'b10;
    localparam logic [1:0] BODY_FLIT = 2'b00;
    localparam logic [1:0] TAIL_FLIT = 2'b01;

    // Router port codes (Lo is the local port this block feeds)
    localparam int Lo = 1;
    localparam int Eo = 2;
    localparam int No = 3;
    localparam int Wo = 4;
    localparam int So = 5;

    // Mesh geometry and node-address widths
    localparam int X_NODE_NUM = 4;
    localparam int Y_NODE_NUM = 4;
    localparam int X_ADDR_W   = 2;
    localparam int Y_ADDR_W   = 2;

    // Packetizer FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BODY  = 3'd1,
        TAIL  = 3'd2,
        ZTAIL = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/ni_packetizer_flit_out_reg.sv
// Output holding register for a flit link: valid/data/type registered toward the consumer.
// Latency: 1 cycle from load to output.
// Backpressure: loads only when empty or when the held flit is accepted; holds stable while out_rdy_i is low.
module flit_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_vld_i,
    input  logic [W-1:0] load_dat_i,
    input  logic [1:0]   load_type_i,
    input  logic         out_rdy_i,
    output logic         can_load_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    output logic [1:0]   out_type_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;
    logic [1:0]   type_q;

    // Free slot either because nothing is held or the held flit leaves this cycle
    assign can_load_o = !vld_q || out_rdy_i;

    // Holding register: refills only when the slot frees up, so a stalled flit never changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            type_q <= 2'b00;
        end else if (can_load_o) begin
            vld_q <= load_vld_i;
            if (load_vld_i) begin
                dat_q  <= load_dat_i;
                type_q <= load_type_i;
            end
        end
    end

    assign out_vld_o  = vld_q;
    assign out_dat_o  = dat_q;
    assign out_type_o = type_q;

endmodule

// File: rtl/ni_packetizer.sv
// NI transmitter: turns a packet request plus payload words into header/body/tail flits for the router local port.
// Latency: header flit 1 cycle after request accept; 1 flit/cycle sustained.
// Backpressure: flit_ready low stalls pkt_ready/data_ready in the same cycle (except while draining a self-addressed packet).
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int FLIT_W           = 8,
    parameter int X_NODE_NUM_WIDTH = X_ADDR_W,
    parameter int Y_NODE_NUM_WIDTH = Y_ADDR_W,
    parameter int X_S_ADDR         = 1,
    parameter int Y_S_ADDR         = 2,
    parameter int LEN_W            = 4,
    parameter int CNT_W            = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [X_NODE_NUM_WIDTH-1:0] pkt_dest_x,
    input  logic [Y_NODE_NUM_WIDTH-1:0] pkt_dest_y,
    input  logic [LEN_W-1:0]            pkt_len,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic [FLIT_W-1:0]           data_in,
    output logic                        flit_valid,
    input  logic                        flit_ready,
    output logic [FLIT_W-1:0]           flit_data,
    output logic [1:0]                  flit_type,
    output logic                        drop_pulse,
    output logic [CNT_W-1:0]            pkt_sent_cnt
);

    localparam logic [X_NODE_NUM_WIDTH-1:0] SRC_X = X_NODE_NUM_WIDTH'(X_S_ADDR);
    localparam logic [Y_NODE_NUM_WIDTH-1:0] SRC_Y = Y_NODE_NUM_WIDTH'(Y_S_ADDR);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               ld_vld;
    logic [FLIT_W-1:0]  ld_dat;
    logic [1:0]         ld_type;
    logic               can_load;
    logic               self_hit;
    logic [FLIT_W-1:0]  hdr_dat;

    // Header layout matches the router's route-compute decode: src y, src x, dest y, dest x (MSB..LSB)
    assign hdr_dat  = FLIT_W'({SRC_Y, SRC_X, pkt_dest_y, pkt_dest_x});
    assign self_hit = (pkt_dest_x == SRC_X) && (pkt_dest_y == SRC_Y);

    // Next-state, handshake and flit-load decisions; handshakes are blocked while reset is held
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        drop_d     = 1'b0;
        ld_vld     = 1'b0;
        ld_dat     = '0;
        ld_type    = BODY_FLIT;
        pkt_ready  = 1'b0;
        data_ready = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_ready = can_load && !rst;
                if (pkt_valid && pkt_ready) begin
                    len_d = pkt_len;
                    if (self_hit) begin
                        // Self-addressed: swallow the payload without emitting anything
                        drop_d  = 1'b1;
                        state_d = (pkt_len == '0) ? IDLE : DRAIN;
                    end else begin
                        ld_vld  = 1'b1;
                        ld_dat  = hdr_dat;
                        ld_type = HDR_FLIT;
                        if (pkt_len == '0)
                            state_d = ZTAIL;
                        else if (pkt_len == LEN_W'(1))
                            state_d = TAIL;
                        else
                            state_d = BODY;
                    end
                end
            end
            BODY: begin
                data_ready = can_load && !rst;
                if (data_valid && data_ready) begin
                    ld_vld = 1'b1;
                    ld_dat = data_in;
                    len_d  = len_q - LEN_W'(1);
                    // The last remaining word goes out as the tail
                    if (len_q == LEN_W'(2))
                        state_d = TAIL;
                end
            end
            TAIL: begin
                data_ready = can_load && !rst;
                if (data_valid && data_ready) begin
                    ld_vld  = 1'b1;
                    ld_dat  = data_in;
                    ld_type = TAIL_FLIT;
                    len_d   = '0;
                    state_d = IDLE;
                end
            end
            ZTAIL: begin
                // Empty packet still needs a tail to close the wormhole
                if (can_load) begin
                    ld_vld  = 1'b1;
                    ld_type = TAIL_FLIT;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                data_ready = !rst;
                if (data_valid && data_ready) begin
                    len_d = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1))
                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, remaining-length and drop-pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
        end
    end

    // Completed-packet counter: counts tails as they leave toward the router, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (flit_valid && flit_ready && (flit_type == TAIL_FLIT))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    flit_out_reg #(
        .W (FLIT_W)
    ) u_out (
        .clk         (clk),
        .rst         (rst),
        .load_vld_i  (ld_vld),
        .load_dat_i  (ld_dat),
        .load_type_i (ld_type),
        .out_rdy_i   (flit_ready),
        .can_load_o  (can_load),
        .out_vld_o   (flit_valid),
        .out_dat_o   (flit_data),
        .out_type_o  (flit_type)
    );

    assign drop_pulse   = drop_q;
    assign pkt_sent_cnt = cnt_q;

endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Network-interface transmitter for the router0 local port: the write side of the header format consumed by the route-compute logic.
- Accepts a packet request (destination x/y plus payload length) and a payload word stream from the local core.
- Emits a header / body / tail flit sequence over a valid/ready link into the router's local input (Lo).
- The header flit carries dest x in bits [1:0] and dest y in bits [3:2], exactly as the router decodes them.

Parameters:
- FLIT_W, 8: flit data width.
- X_NODE_NUM_WIDTH, 2: x address width.
- Y_NODE_NUM_WIDTH, 2: y address width.
- X_S_ADDR, 1: this node's x address.
- Y_S_ADDR, 2: this node's y address.
- LEN_W, 4: payload-length field width.
- CNT_W, 8: sent-packet counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  packet request valid.
- pkt_ready  out  1  packet request accepted.
- pkt_dest_x  in  X_NODE_NUM_WIDTH  destination x.
- pkt_dest_y  in  Y_NODE_NUM_WIDTH  destination y.
- pkt_len  in  LEN_W  payload word count, 0..15.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word consumed.
- data_in  in  FLIT_W  payload word.
- flit_valid  out  1  registered flit valid.
- flit_ready  in  1  router local port accepts the flit.
- flit_data  out  FLIT_W  flit payload.
- flit_type  out  2  flit type: 10 = header, 00 = body, 01 = tail.
- drop_pulse  out  1  one-cycle pulse when a self-addressed packet is discarded.
- pkt_sent_cnt  out  CNT_W  count of completed packets; wraps.

Behaviour:
- Reset: rst asynchronous, active-high. All outputs 0, state IDLE, internal length counter 0. A reset mid-packet abandons the packet and emits no tail; upstream must resend.
- Output register: loads when (!flit_valid || flit_ready). While flit_valid=1 and flit_ready=0, flit_data and flit_type hold stable.
- IDLE:
  - pkt_ready = can_load.
  - On pkt_valid && pkt_ready: latch dest and len; header flit appears on the next cycle (1-cycle latency).
  - Header flit_data = {Y_S_ADDR, X_S_ADDR, dest_y, dest_x}, i.e. [7:6] src y, [5:4] src x, [3:2] dest y, [1:0] dest x. flit_type = 10.
  - Next state: BODY if len ≥ 2; TAIL if len = 1; ZTAIL if len = 0.
- Self-addressed request (dest == own address): accepted, no flits emitted, drop_pulse for 1 cycle. The next state is DRAIN, which consumes len payload words with data_ready=1 and then returns to IDLE. If len = 0, the block returns directly to IDLE.
- BODY:
  - data_ready = can_load. Each data handshake loads data_in with flit_type 00 and decrements remaining.
  - When remaining reaches 1, go to TAIL.
- TAIL: the data handshake loads data_in with flit_type 01, then go to IDLE.
- ZTAIL: loads flit 8'h00 with type 01 without consuming data, then go to IDLE.
- Throughput: 1 flit/cycle when data_valid and flit_ready are held high. No bubble between a tail and the next header, because pkt_ready can be high in the cycle the tail is accepted downstream.
- pkt_sent_cnt increments on the flit_valid && flit_ready handshake of a type-01 flit. It wraps 255 → 0. Dropped packets are not counted.
- No combinational path from flit_ready to flit_valid.
- flit_ready low stalls data_ready and pkt_ready in the same cycle.

Decomposition:
- Shared package (header include) holds:
  - Flit type codes HDR_FLIT = 2'b10, BODY_FLIT = 2'b00, TAIL_FLIT = 2'b01.
  - Port codes Lo = 1, Eo = 2, No = 3, Wo = 4, So = 5.
  - Mesh sizes and node-address widths.
  - FSM state encodings: IDLE, BODY, TAIL, ZTAIL, DRAIN.
- One natural sub-module, flit_out_reg: the output holding register with its load condition, reusable on the router output ports.

Test Plan:
1. Request dest (3,0), len = 3, payload 0xA1, 0xA2, 0xA3, flit_ready = 1 → flits {0x93/10, 0xA1/00, 0xA2/00, 0xA3/01} on 4 consecutive cycles; pkt_sent_cnt = 1.
2. Same packet with flit_ready low for 3 cycles while the header is valid → header 0x93 held unchanged; data_ready = 0 during the stall; sequence then resumes intact.
3. len = 0, dest (0,1) → header 0x94, then tail 0x00/01; data_ready never asserted.
4. Request dest (1,2), len = 2 → no flit_valid; drop_pulse high 1 cycle; 2 payload words consumed; pkt_sent_cnt unchanged.
5. rst asserted after header and one body flit of a len = 4 packet → all outputs 0 immediately; a new len = 1 request then yields a header plus a single tail.
6. 256 back-to-back len = 1 packets → pkt_sent_cnt wraps to 0; no idle cycle between consecutive tail and header.
